// File: rtl/fp_pkg.sv
// Shared flag indices, operand classes and format helpers for the pipelined
// floating-point add/subtract datapath.
package fp_pkg;

    localparam int FLAG_INV = 3;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_exp_ones(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all-ones, only the fraction MSB set.
    function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
        return (128'(fp_exp_ones(exp_w)) << man_w) | (128'(1) << (man_w - 1));
    endfunction

    // Subnormals (exponent 0) are flushed, so they classify as zero.
    function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic frac_nz);
        if (exp_zero) return CLS_ZERO;
        if (!exp_ones) return CLS_NORM;
        return frac_nz ? CLS_NAN : CLS_INF;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input counts as N.
module fp_lzc #(
    parameter int N  = 24,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  value,
    output logic [CW-1:0] count
);

    // Scanning upward lets the highest set bit make the final assignment.
    always_comb begin
        count = CW'(N);
        for (int i = 0; i < N; i++) begin
            if (value[i]) count = CW'(N - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754-style adder/subtractor (align, add, normalise/round) with
// round-to-nearest-even, flush-to-zero, explicit specials and a global stall.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int F   = MAN_W + 4;            // hidden, fraction, guard, round, sticky
    localparam int SAT = MAN_W + 3;
    localparam int SHW = $clog2(SAT + 1);
    localparam int AW  = 2 * MAN_W + 6;
    localparam int LZW = $clog2(MAN_W + 2);
    localparam int EW  = EXP_W + LZW + 1;      // two's-complement exponent headroom
    localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(fp_exp_ones(EXP_W));
    localparam logic [W-1:0]     QNAN     = W'(fp_qnan(EXP_W, MAN_W));

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- stage 1: unpack, order, align ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    fp_class_e        ca, cb;
    logic [MAN_W:0]   ma, mb;

    assign {sa, ea, fa} = a;
    assign eb = b[W-2 -: EXP_W];
    assign fb = b[MAN_W-1:0];
    assign sb = b[W-1] ^ op;
    assign ca = fp_classify(ea == '0, ea == EXP_ONES, fa != '0);
    assign cb = fp_classify(eb == '0, eb == EXP_ONES, fb != '0);
    assign ma = (ca == CLS_NORM) ? {1'b1, fa} : '0;
    assign mb = (cb == CLS_NORM) ? {1'b1, fb} : '0;

    logic             lg_sign, spec_n;
    logic [EXP_W-1:0] lg_exp, sm_exp, exp_diff;
    logic [MAN_W:0]   lg_man, sm_man;
    logic [SHW-1:0]   shamt;
    logic [AW-1:0]    wide;
    logic [F-1:0]     sm_aligned;
    logic [W-1:0]     spec_res_n;
    logic [3:0]       spec_flags_n;

    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        lg_sign      = sa;
        lg_exp       = ea;
        lg_man       = ma;
        sm_exp       = eb;
        sm_man       = mb;
        spec_n       = 1'b0;
        spec_res_n   = '0;
        spec_flags_n = '0;
        if ({eb, mb} > {ea, ma}) begin
            lg_sign = sb;
            lg_exp  = eb;
            lg_man  = mb;
            sm_exp  = ea;
            sm_man  = ma;
        end
        exp_diff   = lg_exp - sm_exp;
        shamt      = (32'(exp_diff) > SAT) ? SHW'(SAT) : SHW'(exp_diff);
        wide       = {sm_man, {(MAN_W + 5){1'b0}}} >> shamt;
        sm_aligned = {wide[AW-1 -: MAN_W + 3], |wide[MAN_W+2:0]};

        if (ca == CLS_NAN || cb == CLS_NAN) begin
            spec_n     = 1'b1;
            spec_res_n = QNAN;
        end else if (ca == CLS_INF && cb == CLS_INF && sa != sb) begin
            spec_n                 = 1'b1;
            spec_res_n             = QNAN;
            spec_flags_n[FLAG_INV] = 1'b1;
        end else if (ca == CLS_INF || cb == CLS_INF) begin
            spec_n     = 1'b1;
            spec_res_n = {(ca == CLS_INF) ? sa : sb, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    logic             s1_valid, s1_spec, s1_sign, s1_sub;
    logic [W-1:0]     s1_spec_res;
    logic [3:0]       s1_spec_flags;
    logic [EXP_W-1:0] s1_exp;
    logic [F-1:0]     s1_lg, s1_sm;

    // NOTE: only valid bits are reset; datapath registers are qualified by them,
    // so discarding in-flight work needs nothing more.
    always_ff @(posedge clk) begin : stage1
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_spec       <= spec_n;
                s1_spec_res   <= spec_res_n;
                s1_spec_flags <= spec_flags_n;
                s1_sign       <= lg_sign;
                s1_sub        <= sa ^ sb;
                s1_exp        <= lg_exp;
                s1_lg         <= {lg_man, 3'b000};
                s1_sm         <= sm_aligned;
            end
        end
    end

    // ---------------- stage 2: add / subtract magnitudes ----------------
    logic             s2_valid, s2_spec, s2_sign, s2_sub;
    logic [W-1:0]     s2_spec_res;
    logic [3:0]       s2_spec_flags;
    logic [EXP_W-1:0] s2_exp;
    logic [F:0]       s2_sum;

    always_ff @(posedge clk) begin : stage2
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_spec       <= s1_spec;
                s2_spec_res   <= s1_spec_res;
                s2_spec_flags <= s1_spec_flags;
                s2_sign       <= s1_sign;
                s2_sub        <= s1_sub;
                s2_exp        <= s1_exp;
                s2_sum        <= s1_sub ? ({1'b0, s1_lg} - {1'b0, s1_sm})
                                        : ({1'b0, s1_lg} + {1'b0, s1_sm});
            end
        end
    end

    // ---------------- stage 3: normalise, round, pack ----------------
    logic [LZW-1:0]   lz;
    logic [F-1:0]     norm;
    logic [EW-1:0]    exp_n, exp_r;
    logic [MAN_W:0]   mant;
    logic             inc, inexact;
    logic [MAN_W+1:0] rounded;
    logic [MAN_W-1:0] frac;
    logic [W-1:0]     res_n;
    logic [3:0]       flags_n;

    fp_lzc #(.N(MAN_W + 1), .CW(LZW)) u_lzc (
        .value(s2_sum[F-1 -: MAN_W + 1]),
        .count(lz)
    );

    always_comb begin
        if (s2_sum[F]) begin
            norm  = s2_sum[F:1] | F'(s2_sum[0]);
            exp_n = EW'(s2_exp) + EW'(1);
        end else begin
            norm  = s2_sum[F-1:0] << lz;
            exp_n = EW'(s2_exp) - EW'(lz);
        end
        mant    = norm[F-1:3];
        inc     = norm[2] & (norm[1] | norm[0] | mant[0]);
        inexact = |norm[2:0];
        rounded = {1'b0, mant} + (MAN_W + 2)'(inc);
        exp_r   = rounded[MAN_W+1] ? exp_n + EW'(1) : exp_n;
        frac    = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];

        res_n            = {s2_sign, exp_r[EXP_W-1:0], frac};
        flags_n          = '0;
        flags_n[FLAG_INX] = inexact;
        if (s2_spec) begin
            res_n   = s2_spec_res;
            flags_n = s2_spec_flags;
        end else if (s2_sum == '0) begin
            res_n   = {s2_sign & !s2_sub, {(W - 1){1'b0}}};
            flags_n = '0;
        end else if (!exp_r[EW-1] && exp_r[EW-2:0] >= (EW - 1)'(EXP_ONES)) begin
            res_n             = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            flags_n[FLAG_OVF] = 1'b1;
            flags_n[FLAG_INX] = 1'b1;
        end else if (exp_r[EW-1] || exp_r == '0) begin
            res_n             = {s2_sign, {(W - 1){1'b0}}};
            flags_n[FLAG_UNF] = 1'b1;
            flags_n[FLAG_INX] = 1'b1;
        end
    end

    // NOTE: non-blocking assignments make every stage sample its feeder's old value.
    always_ff @(posedge clk) begin : stage3
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                result <= res_n;
                flags  <= flags_n;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: scoreboard of hand-derived single-precision
// results, latency, backpressure stability and mid-stream reset.
module tb_fp_addsub_pipe;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          cyc;
        bit          chk_lat;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  flags;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          next_id = 0;
    bit          held_pending = 1'b0;
    bit          saw_stall = 1'b0;
    logic [31:0] held_res;
    logic [3:0]  held_flg;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Output monitor: pops the scoreboard on each consumed result and checks
    // that a result held under backpressure does not change.
    always @(negedge clk) begin
        if (rst) begin
            held_pending = 1'b0;
        end else begin
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (held_pending) begin
                check("held out_valid", 32'(out_valid), 32'd1);
                check("held result", result, held_res);
                check("held flags", 32'(flags), 32'(held_flg));
            end
            held_pending = 1'b0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious out_valid", 32'(out_valid), 32'd0);
                end else if (out_ready) begin
                    e = sb.pop_front();
                    check($sformatf("op%0d result", e.id), result, e.res);
                    check($sformatf("op%0d flags", e.id), 32'(flags), 32'(e.flg));
                    if (e.chk_lat)
                        check($sformatf("op%0d latency", e.id), 32'(cyc - e.cyc), 32'd3);
                end else begin
                    held_pending = 1'b1;
                    held_res     = result;
                    held_flg     = flags;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                        input logic [31:0] er, input logic [3:0] ef, input bit lat);
        int waited;
        waited   = 0;
        a        = av;
        b        = bv;
        op       = opv;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("op%0d accepted", next_id), 32'(in_ready), 32'd1);
        sb.push_back('{res: er, flg: ef, cyc: cyc, chk_lat: lat, id: next_id});
        next_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                       input logic [31:0] er, input logic [3:0] ef);
        send(av, bv, opv, er, ef, 1'b1);
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'h0);
        check("reset flags", 32'(flags), 32'h0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // basic, cancellation, ordering
        one(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0);
        one(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0);
        one(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0);
        // rounding: exact tie to even, sticky above tie, round carry into exponent
        one(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1);
        one(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'h1);
        one(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'h1);
        // specials
        one(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5);
        one(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8);
        one(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8);
        one(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0);
        one(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0);
        // signed zero, subnormal flush, underflow after cancellation
        one(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0);
        one(32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 4'h0);
        one(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'h3);

        // six back-to-back ops with out_ready low for cycles 4..7
        saw_stall = 1'b0;
        fork
            begin
                send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0, 1'b0);
                send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'h0, 1'b0);
                send(32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 4'h0, 1'b0);
                send(32'h3FC00000, 32'h40000000, 1'b0, 32'h40600000, 4'h0, 1'b0);
                send(32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 4'h0, 1'b0);
                send(32'hC0000000, 32'h3F000000, 1'b0, 32'hBFC00000, 4'h0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("in_ready dropped under backpressure", 32'(saw_stall), 32'd1);

        // reset with three operations in flight
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0, 1'b0);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'h0, 1'b0);
        send(32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 4'h0, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid reset out_valid", 32'(out_valid), 32'd0);
        check("mid reset in_ready", 32'(in_ready), 32'd1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        one(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
